// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-to-decode instruction queue.
package fetch_pkg;

    localparam int FQ_DATA_WIDTH = 32;
    localparam int FQ_DEPTH      = 4;
    localparam int FQ_PTR_WIDTH  = $clog2(FQ_DEPTH);

    // addi x0, x0, 0 -- what decode sees when the queue is empty
    localparam logic [FQ_DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [FQ_DATA_WIDTH-1:0] instr;
        logic [FQ_DATA_WIDTH-1:0] pc;
        logic [FQ_DATA_WIDTH-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage: one synchronous write port, one combinational read port.
// The array has no reset; occupancy tracking lives in the parent.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH     = FQ_DEPTH,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  fetch_entry_t         wdata,
    input  logic [PTR_WIDTH-1:0] raddr,
    output fetch_entry_t         rdata
);

    fetch_entry_t mem [DEPTH];

    // Write the pushed entry at the tail slot.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode. First-word-fall-through FIFO:
// the head entry is presented to decode combinationally from storage, and
// fetch is throttled only when every slot is occupied.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = FQ_DATA_WIDTH,
    parameter int DEPTH      = FQ_DEPTH,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_valid,
    input  logic [DATA_WIDTH-1:0] instrF,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  fetch_ready,
    input  logic                  flush,
    input  logic                  dec_ready,
    output logic                  validD,
    output logic [DATA_WIDTH-1:0] instrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic [PTR_WIDTH:0]    count
);

    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   CNT_ONE = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0]   CNT_MAX = (PTR_WIDTH+1)'(DEPTH);

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 push;
    logic                 pop;
    fetch_entry_t         wdata;
    fetch_entry_t         rdata;

    // Ready depends only on occupancy, so no combinational path from decode
    // stall back into the fetch enable; a full queue refuses a push even if
    // decode drains an entry in the same cycle.
    assign fetch_ready = (count != CNT_MAX);
    assign validD      = (count != '0);
    assign push        = fetch_valid & fetch_ready & ~flush;
    assign pop         = validD & dec_ready & ~flush;

    assign wdata.instr    = instrF;
    assign wdata.pc       = PCF;
    assign wdata.pc_plus4 = PCPlus4F;

    fetch_queue_mem #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push & reset),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Pointer and occupancy update; reset beats flush, flush beats traffic.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Head entry to decode, or a NOP bubble when nothing is buffered.
    always_comb begin
        instrD   = NOP_INSTR;
        PCD      = '0;
        PCPlus4D = '0;
        if (validD) begin
            instrD   = rdata.instr;
            PCD      = rdata.pc;
            PCPlus4D = rdata.pc_plus4;
        end
    end

endmodule
